// File: rtl/qc_ldpc_encoder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ldpc_pkg : shared sizes, circulant shift table and encoder states
// Rev 1.0
// ---------------------------------------------------------------------------
package ldpc_pkg;

  localparam int L          = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int K          = 6;
  localparam int J          = 3;

  localparam int RW    = (J > 1) ? $clog2(J) : 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int CNT_W = (KW > RW) ? KW : RW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSG  = 2'd1,
    PAR  = 2'd2
  } enc_state_t;

  // Shift of circulant (r,j); L is a power of two so the mod is a truncation.
  function automatic logic [ADDR_WIDTH-1:0] shift_of(input int r, input int j);
    return ADDR_WIDTH'((r * j) % L);
  endfunction

endpackage
`default_nettype wire

// File: rtl/qc_ldpc_encoder_acc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qc_parity_acc : J x L parity accumulator with clear, toggle and read ports
// Rev 1.0
// ---------------------------------------------------------------------------
module qc_parity_acc
  import ldpc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  tgl_en,
  input  logic [CNT_W-1:0]      tgl_j,
  input  logic [ADDR_WIDTH-1:0] tgl_t,
  input  logic                  tgl_bit,
  input  logic [RW-1:0]         rd_r,
  input  logic [ADDR_WIDTH-1:0] rd_u,
  output logic                  rd_bit
);

  logic [L-1:0] acc_q [J];
  logic [L-1:0] acc_d [J];

  always_comb begin
    for (int r = 0; r < J; r++) begin
      acc_d[r] = clr ? '0 : acc_q[r];
    end
    // Message bit m_j[t] feeds parity bit (t - s(r,j)) of every row group.
    if (tgl_en && tgl_bit) begin
      for (int r = 0; r < J; r++) begin
        acc_d[r][tgl_t - shift_of(r, int'(tgl_j))] = ~acc_d[r][tgl_t - shift_of(r, int'(tgl_j))];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < J; r++) acc_q[r] <= '0;
    end else begin
      for (int r = 0; r < J; r++) acc_q[r] <= acc_d[r];
    end
  end

  assign rd_bit = acc_q[rd_r][rd_u];

endmodule
`default_nettype wire

// File: rtl/qc_ldpc_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qc_ldpc_encoder : serial systematic QC-LDPC encoder, parity built on the fly
// Rev 1.0
// ---------------------------------------------------------------------------
module qc_ldpc_encoder
  import ldpc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_data,
  output logic in_ready,
  output logic out_valid,
  output logic out_data,
  input  logic out_ready,
  output logic out_parity,
  output logic out_last,
  output logic busy
);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Reset asserts asynchronously but is released on a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  enc_state_t            state_q,      state_d;
  logic [CNT_W-1:0]      blk_q,        blk_d;
  logic [ADDR_WIDTH-1:0] pos_q,        pos_d;
  logic                  out_valid_q,  out_valid_d;
  logic                  out_data_q,   out_data_d;
  logic                  out_parity_q, out_parity_d;
  logic                  out_last_q,   out_last_d;

  logic stage_free;
  logic accept;
  logic pos_wrap;
  logic rd_bit;

  assign stage_free = !out_valid_q || out_ready;
  assign in_ready   = rst_n && (state_q != PAR) && stage_free;
  assign accept     = in_valid && in_ready;
  assign pos_wrap   = (pos_q == ADDR_WIDTH'(L - 1));

  qc_parity_acc u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept && (state_q == IDLE)),
    .tgl_en (accept),
    .tgl_j  (blk_q),
    .tgl_t  (pos_q),
    .tgl_bit(in_data),
    .rd_r   (blk_q[RW-1:0]),
    .rd_u   (pos_q),
    .rd_bit (rd_bit)
  );

  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    pos_d        = pos_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_parity_d = out_parity_q;
    out_last_d   = out_last_q;
    if (stage_free) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    unique case (state_q)
      IDLE, MSG: begin
        if (accept) begin
          out_valid_d  = 1'b1;
          out_data_d   = in_data;
          out_parity_d = 1'b0;
          out_last_d   = 1'b0;
          state_d      = MSG;
          pos_d        = pos_q + 1'b1;
          if (pos_wrap) begin
            blk_d = blk_q + 1'b1;
            if (blk_q == CNT_W'(K - 1)) begin
              blk_d   = '0;
              state_d = PAR;
            end
          end
        end
      end
      PAR: begin
        if (stage_free) begin
          out_valid_d  = 1'b1;
          out_data_d   = rd_bit;
          out_parity_d = 1'b1;
          out_last_d   = 1'b0;
          pos_d        = pos_q + 1'b1;
          if (pos_wrap) begin
            blk_d = blk_q + 1'b1;
            if (blk_q == CNT_W'(J - 1)) begin
              blk_d      = '0;
              out_last_d = 1'b1;
              state_d    = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      blk_q        <= '0;
      pos_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 1'b0;
      out_parity_q <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_q        <= blk_d;
      pos_q        <= pos_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_parity_q <= out_parity_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_parity = out_parity_q;
  assign out_last   = out_last_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_qc_ldpc_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_qc_ldpc_encoder : randomized bench against a parity-equation model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_qc_ldpc_encoder;
  import ldpc_pkg::*;

  localparam int M = K * L;
  localparam int N = (K + J) * L;

  logic clk = 1'b0;
  logic reset, in_valid, in_data, in_ready;
  logic out_valid, out_data, out_ready, out_parity, out_last, busy;

  int n_cmp = 0;
  int n_err = 0;

  bit msg  [M];
  bit expc [N];
  bit rx   [N];

  always #5 clk = ~clk;

  qc_ldpc_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_parity(out_parity),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Parity straight from the code definition: p_r[u] = XOR_j m_j[(u + r*j) mod L].
  function automatic void build_expected();
    for (int i = 0; i < M; i++) expc[i] = msg[i];
    for (int r = 0; r < J; r++)
      for (int u = 0; u < L; u++) begin
        bit p = 1'b0;
        for (int j = 0; j < K; j++) p ^= msg[j*L + (u + (r*j) % L) % L];
        expc[M + r*L + u] = p;
      end
  endfunction

  function automatic int syndrome_weight();
    int w = 0;
    for (int r = 0; r < J; r++)
      for (int u = 0; u < L; u++) begin
        bit s = rx[M + r*L + u];
        for (int j = 0; j < K; j++) s ^= rx[j*L + (u + (r*j) % L) % L];
        w += int'(s);
      end
    return w;
  endfunction

  function automatic int parity_ones();
    int w = 0;
    for (int i = M; i < N; i++) w += int'(rx[i]);
    return w;
  endfunction

  task automatic run_frame(input bit bp, input int abort_at, output bit aborted);
    int  mi = 0, oi = 0, cyc = 0, first_cyc = -1;
    bit  stalled = 1'b0, hd = 1'b0, hp = 1'b0, hl = 1'b0, exp_rdy;
    aborted = 1'b0;
    build_expected();
    while (oi < N && cyc < 6000) begin
      @(negedge clk);
      out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_valid  = (mi < M) && (bp ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_data   = (mi < M) ? msg[mi] : 1'b0;
      #1;
      if (stalled) begin
        check("hold_valid",  out_valid,  1);
        check("hold_data",   out_data,   hd);
        check("hold_parity", out_parity, hp);
        check("hold_last",   out_last,   hl);
      end
      exp_rdy = ((mi < M) || (out_valid && oi == N-1)) ? (!out_valid || out_ready) : 1'b0;
      check("in_ready", in_ready, exp_rdy);
      if (out_valid && out_ready) begin
        check("out_data",   out_data,   expc[oi]);
        check("out_parity", out_parity, oi >= M);
        check("out_last",   out_last,   oi == N-1);
        rx[oi] = out_data;
        if (oi == N-1 && !bp) check("frame_cycles", cyc - first_cyc, N);
        oi++;
      end
      stalled = out_valid && !out_ready;
      hd = out_data; hp = out_parity; hl = out_last;
      if (in_valid && in_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        mi++;
      end
      cyc++;
      if (abort_at >= 0 && mi == abort_at) begin
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      check("frame_complete", oi, N);
      check("syndrome", syndrome_weight(), 0);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("busy_after", busy, 0);
      check("valid_after", out_valid, 0);
    end
  endtask

  initial begin
    bit ab;
    reset = 1'b0; in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid",  out_valid,  0);
    check("rst_out_data",   out_data,   0);
    check("rst_out_parity", out_parity, 0);
    check("rst_out_last",   out_last,   0);
    check("rst_busy",       busy,       0);
    check("rst_in_ready",   in_ready,   0);
    @(negedge clk) reset = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < M; i++) msg[i] = 1'b0;
    run_frame(1'b0, -1, ab);
    check("zero_parity_ones", parity_ones(), 0);

    msg[2*L + 5] = 1'b1;
    run_frame(1'b0, -1, ab);
    check("m2_5_ones", parity_ones(), 3);
    check("m2_5_p0", rx[197], 1);
    check("m2_5_p1", rx[227], 1);
    check("m2_5_p2", rx[257], 1);

    msg[2*L + 5] = 1'b0;
    msg[5*L] = 1'b1;
    run_frame(1'b0, -1, ab);
    check("m5_0_ones", parity_ones(), 3);
    check("m5_0_p0", rx[M + 0], 1);
    check("m5_0_p1", rx[M + L + 27], 1);
    check("m5_0_p2", rx[M + 2*L + 22], 1);

    for (int i = 0; i < M; i++) msg[i] = 1'b1;
    run_frame(1'b0, -1, ab);
    check("ones_parity_ones", parity_ones(), 0);

    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < M; i++) msg[i] = bit'($urandom_range(0, 1));
      run_frame(1'b1, -1, ab);
    end

    for (int i = 0; i < M; i++) msg[i] = 1'b1;
    run_frame(1'b0, 100, ab);
    check("abort_reached", ab, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid",    out_valid, 0);
    check("mid_rst_last",     out_last,  0);
    check("mid_rst_busy",     busy,      0);
    check("mid_rst_in_ready", in_ready,  0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < M; i++) msg[i] = bit'($urandom_range(0, 1));
    run_frame(1'b0, -1, ab);

    for (int f = 0; f < 100; f++) begin
      for (int i = 0; i < M; i++) msg[i] = bit'($urandom_range(0, 1));
      run_frame(f % 10 == 3, -1, ab);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
